cdc_fifo_read_port: RTL and testbench
=====================================

CDC_FIFO_READ_PORT -- requirements
Module: cdc_fifo_read_port

Interface
REQ-001 Parameters SHALL be:
  - ADDRESS_WIDTH, default 4: RAM address bits; depth = 2^ADDRESS_WIDTH.
  - SYNC_STAGES, default 2: flops in the write-pointer synchroniser; legal range 2..4.
  - ALMOST_EMPTY_LEVEL, default 2: fill level at or below which almost_empty asserts; legal range 1..depth-1.
REQ-002 Ports SHALL be, clock and reset first:
  - clock, input, 1: read-domain clock; single clock for the block.
  - reset_n, input, 1: synchronous, active-low reset.
  - increment, input, 1: consumer request to pop one entry this cycle.
  - clear_error, input, 1: clears the sticky underflow flag.
  - write_pointer_gray, input, ADDRESS_WIDTH+1: Gray-coded write pointer from the write domain; asynchronous to clock.
  - read_address, output, ADDRESS_WIDTH: RAM read address (low bits of the read pointer).
  - read_pointer_gray, output, ADDRESS_WIDTH+1: registered Gray-coded read pointer, sent to the write domain.
  - empty, output, 1: no entries are readable.
  - almost_empty, output, 1: fill_level <= ALMOST_EMPTY_LEVEL.
  - fill_level, output, ADDRESS_WIDTH+1: entries visible to the read side.
  - underflow, output, 1: sticky; set when a pop is attempted while empty.

Function
REQ-003 write_pointer_gray SHALL pass through a SYNC_STAGES-deep flop chain, all stages clocked by clock; only the last stage feeds downstream logic.
REQ-004 The synchronised Gray pointer SHALL be converted to binary as bit i = XOR of Gray bits ADDRESS_WIDTH..i.
REQ-005 The block SHALL hold an (ADDRESS_WIDTH+1)-bit binary read pointer; the extra MSB is the wrap bit.
REQ-006 read_address SHALL equal read pointer bits [ADDRESS_WIDTH-1:0].
REQ-007 fill_level SHALL equal (synced write binary - read pointer) modulo 2^(ADDRESS_WIDTH+1), computed combinationally from registers.
REQ-008 empty SHALL be 1 exactly when the synced write binary pointer equals the read pointer in all ADDRESS_WIDTH+1 bits.
REQ-009 pop SHALL be defined as increment AND NOT empty; on a pop the read pointer SHALL advance by 1 at the next clock edge.
REQ-010 The read pointer SHALL wrap from 2^(ADDRESS_WIDTH+1)-1 to 0, toggling the wrap bit each time read_address wraps past depth-1.
REQ-011 read_pointer_gray SHALL be a register loaded with the Gray code of the next read pointer (next XOR next>>1), so it changes on the same edge as the pointer, one bit per increment.
REQ-012 Timing and latency:
  - A write-pointer change SHALL affect empty, almost_empty and fill_level exactly SYNC_STAGES clock edges after it is sampled.
  - A pop SHALL update these outputs one edge later.
REQ-013 On increment=1 with empty=1:
  - The pointer SHALL hold.
  - underflow SHALL be set at the next edge and remain set until clear_error=1 or reset.
REQ-014 If clear_error=1 and an underflow condition occur in the same cycle, the set SHALL take priority (underflow=1).
REQ-015 If the write pointer advances in the same cycle as a pop, both SHALL take effect independently; fill_level reflects both once the write change is synchronised.
REQ-016 fill_level SHALL never exceed depth provided the write side honours full; the block does not check this.

Reset
REQ-017 With reset_n=0 at a rising edge, all synchroniser stages, the read pointer, read_pointer_gray and underflow SHALL clear to 0.
REQ-018 After reset: empty=1, almost_empty=1, fill_level=0, read_address=0.
REQ-019 Reset asserted mid-operation SHALL discard all state at that edge, with no pop performed in that cycle.
REQ-020 Reset SHALL have priority over increment and clear_error.

Verification (ADDRESS_WIDTH=4, SYNC_STAGES=2, ALMOST_EMPTY_LEVEL=2)
REQ-021 Sync latency: reset, then drive write_pointer_gray=Gray(3)=5'b00010 -> empty stays 1 for 2 edges, then empty=0, fill_level=3, almost_empty=0.
REQ-022 Drain: with fill_level=3, hold increment=1 for 4 cycles -> read_address 0,1,2 then holds at 3; empty=1 after the 3rd pop; underflow=1 after the 4th cycle.
REQ-023 Error clear: with underflow=1, pulse clear_error for 1 cycle with increment=0 -> underflow=0; repeat with increment=1 and empty=1 in the same cycle -> underflow stays 1.
REQ-024 Wrap: stream 40 entries via a write-pointer model with continuous pops -> read_address wraps 15->0; the wrap bit toggles at pointers 16 and 32; read_pointer_gray changes exactly one bit per pop; fill_level never exceeds 16.
REQ-025 Full boundary: write pointer = read pointer + 16 (MSB differs, low bits equal) -> empty=0, fill_level=16.
REQ-026 Reset mid-stream: assert reset_n=0 for 1 edge while fill_level=5 and increment=1 -> all outputs return to their reset values (REQ-018) at that edge; underflow=0.

Source files
------------

// File: rtl/cdc_fifo_read_port_if.sv
// cdc_fifo_read_port_if: consumer-side handshake and status signals of the FIFO read port.
interface cdc_fifo_read_port_if #(
    parameter int ADDRESS_WIDTH = 4
);
    logic                     increment;
    logic                     clear_error;
    logic [ADDRESS_WIDTH:0]   write_pointer_gray;
    logic [ADDRESS_WIDTH-1:0] read_address;
    logic [ADDRESS_WIDTH:0]   read_pointer_gray;
    logic                     empty;
    logic                     almost_empty;
    logic [ADDRESS_WIDTH:0]   fill_level;
    logic                     underflow;
    modport master (
        output increment, clear_error, write_pointer_gray,
        input  read_address, read_pointer_gray, empty, almost_empty, fill_level, underflow
    );
    modport slave (
        input  increment, clear_error, write_pointer_gray,
        output read_address, read_pointer_gray, empty, almost_empty, fill_level, underflow
    );
endinterface

// File: rtl/cdc_fifo_read_port.sv
// cdc_fifo_read_port: read-side pointer logic of an async FIFO with a Gray write-pointer synchroniser.
module cdc_fifo_read_port #(
    parameter int ADDRESS_WIDTH      = 4,
    parameter int SYNC_STAGES        = 2,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input logic clock,
    input logic reset_n,
    cdc_fifo_read_port_if.slave port
);
    localparam int AW = ADDRESS_WIDTH;
    logic [SYNC_STAGES-1:0][AW:0] sync;
    logic [AW:0] write_binary, read_pointer, next_pointer, fill;
    logic pop;
    // Only the last synchroniser stage is decoded; earlier stages may be metastable.
    always_comb begin
        write_binary = '0;
        for (int i = 0; i <= AW; i++) write_binary[i] = ^(sync[SYNC_STAGES-1] >> i);
    end
    assign fill              = write_binary - read_pointer;
    assign port.fill_level   = fill;
    assign port.empty        = fill == '0;
    assign port.almost_empty = fill <= (AW+1)'(ALMOST_EMPTY_LEVEL);
    assign port.read_address = read_pointer[AW-1:0];
    assign pop               = port.increment & ~port.empty;
    assign next_pointer      = read_pointer + (AW+1)'(pop);
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync                   <= '0;
            read_pointer           <= '0;
            port.read_pointer_gray <= '0;
            port.underflow         <= 1'b0;
        end else begin
            sync                   <= {sync[SYNC_STAGES-2:0], port.write_pointer_gray};
            read_pointer           <= next_pointer;
            port.read_pointer_gray <= next_pointer ^ (next_pointer >> 1);
            port.underflow         <= (port.increment & port.empty) | (port.underflow & ~port.clear_error);
        end
    end
endmodule

// File: tb/tb_cdc_fifo_read_port.sv
// tb_cdc_fifo_read_port: directed and randomized checks of the read port against a queue-delay pointer model.
module tb_cdc_fifo_read_port;
    localparam int AW = 4, SS = 2, AEL = 2, DEPTH = 16;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    cdc_fifo_read_port_if #(.ADDRESS_WIDTH(AW)) bus ();
    cdc_fifo_read_port #(.ADDRESS_WIDTH(AW), .SYNC_STAGES(SS), .ALMOST_EMPTY_LEVEL(AEL)) dut (
        .clock(clock), .reset_n(reset_n), .port(bus)
    );
    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    int wptr = 0, m_rptr = 0, vis = 0, pops = 0, msb_toggles = 0;
    bit m_under = 1'b0;
    int q[$];
    logic [AW:0] prev_gray = '0;

    function automatic int gray(int v);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic set_w(int v);
        wptr = v & 31;
        bus.write_pointer_gray = 5'(gray(wptr));
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial for (int i = 0; i < SS; i++) q.push_back(0);

    // Reference: the write pointer becomes visible after SS edges; read pointer counts pops mod 32.
    always @(posedge clock) begin
        int mf;
        bit me, pop, rst;
        mf = (vis - m_rptr) & 31;
        me = (mf == 0);
        rst = !reset_n;
        pop = 1'b0;
        if (rst) begin
            m_rptr = 0;
            m_under = 1'b0;
            foreach (q[i]) q[i] = 0;
        end else begin
            pop = bus.increment && !me;
            m_under = (bus.increment && me) || (m_under && !bus.clear_error);
            m_rptr = (m_rptr + int'(pop)) & 31;
            pops += int'(pop);
            q.push_back(wptr);
            void'(q.pop_front());
        end
        vis = q[0];
        #1;
        mf = (vis - m_rptr) & 31;
        chk("read_address", 32'(bus.read_address), m_rptr & 15);
        chk("read_pointer_gray", 32'(bus.read_pointer_gray), gray(m_rptr));
        chk("fill_level", 32'(bus.fill_level), mf);
        chk("empty", 32'(bus.empty), 32'(mf == 0));
        chk("almost_empty", 32'(bus.almost_empty), 32'(mf <= AEL));
        chk("underflow", 32'(bus.underflow), 32'(m_under));
        chk("fill_bound", 32'(bus.fill_level <= DEPTH), 1);
        if (!rst) begin
            chk("gray_one_bit", $countones(bus.read_pointer_gray ^ prev_gray), 32'(pop));
            if (bus.read_pointer_gray[AW] != prev_gray[AW]) msb_toggles++;
        end
        prev_gray = bus.read_pointer_gray;
    end

    initial begin
        int addr_exp[4] = '{1, 2, 3, 3};
        bit done;
        bus.increment = 1'b0;
        bus.clear_error = 1'b0;
        set_w(0);
        repeat (2) step();
        reset_n = 1'b1;
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_almost", 32'(bus.almost_empty), 1);
        chk("rst_fill", 32'(bus.fill_level), 0);
        chk("rst_addr", 32'(bus.read_address), 0);
        chk("rst_gray", 32'(bus.read_pointer_gray), 0);
        chk("rst_underflow", 32'(bus.underflow), 0);
        // Synchroniser latency
        set_w(3);
        step();
        chk("sync_edge1_empty", 32'(bus.empty), 1);
        step();
        chk("sync_edge2_empty", 32'(bus.empty), 0);
        chk("sync_edge2_fill", 32'(bus.fill_level), 3);
        chk("sync_edge2_almost", 32'(bus.almost_empty), 0);
        // Drain past empty
        bus.increment = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_addr", 32'(bus.read_address), addr_exp[i]);
            if (i == 2) begin
                chk("drain_empty", 32'(bus.empty), 1);
                chk("drain_no_underflow_yet", 32'(bus.underflow), 0);
            end
        end
        chk("drain_underflow", 32'(bus.underflow), 1);
        // Error clear, then set-over-clear priority
        bus.increment = 1'b0;
        bus.clear_error = 1'b1;
        step();
        chk("clear_underflow", 32'(bus.underflow), 0);
        bus.clear_error = 1'b0;
        bus.increment = 1'b1;
        step();
        chk("reset_underflow", 32'(bus.underflow), 1);
        bus.clear_error = 1'b1;
        step();
        chk("set_beats_clear", 32'(bus.underflow), 1);
        bus.clear_error = 1'b0;
        bus.increment = 1'b0;
        // Full boundary: write = read + 16
        set_w(3 + 16);
        repeat (2) step();
        chk("full_fill", 32'(bus.fill_level), 16);
        chk("full_empty", 32'(bus.empty), 0);
        // Drain to fill 5, then reset while popping
        bus.increment = 1'b1;
        repeat (11) step();
        chk("pre_reset_fill", 32'(bus.fill_level), 5);
        chk("pre_reset_addr", 32'(bus.read_address), 14);
        reset_n = 1'b0;
        step();
        chk("mid_reset_fill", 32'(bus.fill_level), 0);
        chk("mid_reset_addr", 32'(bus.read_address), 0);
        chk("mid_reset_empty", 32'(bus.empty), 1);
        chk("mid_reset_underflow", 32'(bus.underflow), 0);
        reset_n = 1'b1;
        set_w(0);
        bus.increment = 1'b0;
        bus.clear_error = 1'b1;
        step();
        bus.clear_error = 1'b0;
        // Stream 40 entries with continuous pops
        pops = 0;
        msb_toggles = 0;
        bus.increment = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            if (wptr < 40 && ((wptr - m_rptr) & 31) < DEPTH) set_w(wptr + 1);
            step();
            done = (pops >= 40);
        end
        chk("stream_done", 32'(done), 1);
        chk("stream_pops", pops, 40);
        chk("msb_toggles", msb_toggles, 2);
        chk("stream_addr", 32'(bus.read_address), 40 & 15);
        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            bus.increment = ($urandom_range(0, 9) < 6);
            bus.clear_error = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                set_w(0);
            end else begin
                reset_n = 1'b1;
                if ($urandom_range(0, 1) == 1 && ((wptr - m_rptr) & 31) < DEPTH) set_w(wptr + 1);
            end
            step();
        end
        reset_n = 1'b1;
        bus.increment = 1'b0;
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
